// File: rtl/hash_matrix_loader_pkg.sv
// Shared types and constants for the H3 matrix loader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the matrix geometry, the power-up matrix set and the loader FSM states.
package hash_matrix_pkg;

  localparam int NUMBER_OF_TABLES = 4;
  localparam int HASH_ADR_WIDTH   = 5;
  localparam int KEY_WIDTH        = 16;

  localparam int TBL_CNT_W = (NUMBER_OF_TABLES > 1) ? $clog2(NUMBER_OF_TABLES) : 1;
  localparam int ROW_CNT_W = (HASH_ADR_WIDTH > 1) ? $clog2(HASH_ADR_WIDTH) : 1;
  localparam int MATRIX_W  = NUMBER_OF_TABLES * HASH_ADR_WIDTH * KEY_WIDTH;

  typedef logic [KEY_WIDTH-1:0] row_t;
  typedef row_t matrix_set_t [NUMBER_OF_TABLES][HASH_ADR_WIDTH];

  // Matrix set used out of reset, before any host reconfiguration.
  localparam matrix_set_t DEFAULT_Q_MATRIX = '{
    '{16'h9e37, 16'h79b9, 16'h7f4a, 16'h7c15, 16'hf39c},
    '{16'hc6a4, 16'ha793, 16'h5d58, 16'h8b3c, 16'h1f12},
    '{16'h2545, 16'hf491, 16'h4f6c, 16'hdd1d, 16'h6a09},
    '{16'hbb67, 16'hae85, 16'h3c6e, 16'hf372, 16'ha54f}
  };

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_IDLE = 2'd2,
    COMMIT    = 2'd3
  } loader_state_t;

  // Bit offset of row r of table t in the flat matrix bus.
  function automatic int row_offset(input int t, input int r);
    return (t * HASH_ADR_WIDTH + r) * KEY_WIDTH;
  endfunction

endpackage

// File: rtl/hash_matrix_loader_matrix_bank.sv
// Double-buffered matrix storage: shadow bank written row by row, active bank copied whole.
// Latency: row write and shadow->active copy both take effect on the next clk_i edge.
// Backpressure: none; the write port and copy strobe are always accepted.
//
// Ports:
//   clk_i, reset_i  : clock, synchronous active-high reset (both banks -> default set)
//   we_i, wr_tbl_i, wr_row_i, wr_data_i : shadow row write port
//   copy_i          : copy the whole shadow bank into the active bank
//   matrixes_o      : flat active bank, row r of table t at row_offset(t, r)
module matrix_bank
  import hash_matrix_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 we_i,
  input  logic [TBL_CNT_W-1:0] wr_tbl_i,
  input  logic [ROW_CNT_W-1:0] wr_row_i,
  input  logic [KEY_WIDTH-1:0] wr_data_i,
  input  logic                 copy_i,
  output logic [MATRIX_W-1:0]  matrixes_o
);

  matrix_set_t shadow_q, shadow_d;
  matrix_set_t active_q, active_d;

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (we_i) begin
      shadow_d[wr_tbl_i][wr_row_i] = wr_data_i;
    end
    // Copy takes the registered shadow; the loader never writes and copies in the same cycle.
    if (copy_i) begin
      active_d = shadow_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shadow_q <= DEFAULT_Q_MATRIX;
      active_q <= DEFAULT_Q_MATRIX;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    matrixes_o = '0;
    for (int t = 0; t < NUMBER_OF_TABLES; t++) begin
      for (int r = 0; r < HASH_ADR_WIDTH; r++) begin
        matrixes_o[row_offset(t, r) +: KEY_WIDTH] = active_q[t][r];
      end
    end
  end

endmodule

// File: rtl/hash_matrix_loader.sv
// Runtime H3 matrix reconfiguration: streams a new set into a shadow bank, swaps it in when tables idle.
// Latency: last beat at edge k -> WAIT_IDLE in k+1, COMMIT (new matrixes_o, swap_done_o) in k+2 if idle.
// Backpressure: row_ready_o is high only in LOAD; WAIT_IDLE holds freeze_o until tables_idle_i.
//
// Ports:
//   clk_i, reset_i        : clock, synchronous active-high reset
//   start_i, abort_i      : begin a new load (IDLE only) / drop a partial or pending set
//   row_valid_i, row_ready_o, row_data_i : row stream, table-major then row-minor
//   tables_idle_i, freeze_o : quiesce handshake with the hashtables
//   busy_o, swap_done_o   : status, one-cycle pulse when the new set becomes active
//   matrixes_o            : flat active matrix set
module hash_matrix_loader
  import hash_matrix_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 row_valid_i,
  output logic                 row_ready_o,
  input  logic [KEY_WIDTH-1:0] row_data_i,
  input  logic                 tables_idle_i,
  output logic                 freeze_o,
  output logic                 busy_o,
  output logic                 swap_done_o,
  output logic [MATRIX_W-1:0]  matrixes_o
);

  localparam logic [TBL_CNT_W-1:0] LAST_TBL = TBL_CNT_W'(NUMBER_OF_TABLES - 1);
  localparam logic [ROW_CNT_W-1:0] LAST_ROW = ROW_CNT_W'(HASH_ADR_WIDTH - 1);

  loader_state_t        state_q, state_d;
  logic [TBL_CNT_W-1:0] tbl_q, tbl_d;
  logic [ROW_CNT_W-1:0] row_q, row_d;
  logic                 row_ready_q, row_ready_d;
  logic                 freeze_q, freeze_d;
  logic                 busy_q, busy_d;
  logic                 swap_done_q, swap_done_d;
  logic                 bank_we;
  logic                 bank_copy;

  always_comb begin
    state_d   = state_q;
    tbl_d     = tbl_q;
    row_d     = row_q;
    bank_we   = 1'b0;
    bank_copy = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = LOAD;
          tbl_d   = '0;
          row_d   = '0;
        end
      end
      LOAD: begin
        // Abort wins over a beat presented in the same cycle.
        if (abort_i) begin
          state_d = IDLE;
        end else if (row_valid_i && row_ready_q) begin
          bank_we = 1'b1;
          if (row_q == LAST_ROW) begin
            row_d = '0;
            if (tbl_q == LAST_TBL) begin
              state_d = WAIT_IDLE;
            end else begin
              tbl_d = tbl_q + 1'b1;
            end
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      WAIT_IDLE: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (tables_idle_i) begin
          state_d   = COMMIT;
          bank_copy = 1'b1;
        end
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they line up with state_q after the edge.
    row_ready_d = (state_d == LOAD);
    freeze_d    = (state_d == WAIT_IDLE) || (state_d == COMMIT);
    busy_d      = (state_d != IDLE);
    swap_done_d = (state_d == COMMIT);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      tbl_q       <= '0;
      row_q       <= '0;
      row_ready_q <= 1'b0;
      freeze_q    <= 1'b0;
      busy_q      <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tbl_q       <= tbl_d;
      row_q       <= row_d;
      row_ready_q <= row_ready_d;
      freeze_q    <= freeze_d;
      busy_q      <= busy_d;
      swap_done_q <= swap_done_d;
    end
  end

  assign row_ready_o = row_ready_q;
  assign freeze_o    = freeze_q;
  assign busy_o      = busy_q;
  assign swap_done_o = swap_done_q;

  matrix_bank u_bank (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .we_i       (bank_we),
    .wr_tbl_i   (tbl_q),
    .wr_row_i   (row_q),
    .wr_data_i  (row_data_i),
    .copy_i     (bank_copy),
    .matrixes_o (matrixes_o)
  );

endmodule

// File: tb/tb_hash_matrix_loader.sv
// Self-checking bench for hash_matrix_loader against a behavioural model of the active matrix set.
// Latency: n/a (testbench).
// Backpressure: beats are counted as accepted only when row_valid_i meets row_ready_o.
module tb_hash_matrix_loader;

  localparam int NT = 4;
  localparam int HA = 5;
  localparam int KW = 16;
  localparam int NB = NT * HA;
  localparam int MW = NT * HA * KW;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          start_i;
  logic          abort_i;
  logic          row_valid_i;
  logic          row_ready_o;
  logic [KW-1:0] row_data_i;
  logic          tables_idle_i;
  logic          freeze_o;
  logic          busy_o;
  logic          swap_done_o;
  logic [MW-1:0] matrixes_o;

  int checks = 0;
  int errors = 0;

  // Model: matrices the hash units should currently see, and the set being streamed in.
  logic [KW-1:0] exp_act [NT][HA];
  logic [KW-1:0] rows [NB];

  always #5 clk = ~clk;

  hash_matrix_loader dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .row_valid_i   (row_valid_i),
    .row_ready_o   (row_ready_o),
    .row_data_i    (row_data_i),
    .tables_idle_i (tables_idle_i),
    .freeze_o      (freeze_o),
    .busy_o        (busy_o),
    .swap_done_o   (swap_done_o),
    .matrixes_o    (matrixes_o)
  );

  function automatic logic [MW-1:0] flat_exp();
    logic [MW-1:0] f;
    f = '0;
    for (int t = 0; t < NT; t++)
      for (int r = 0; r < HA; r++)
        f[(t * HA + r) * KW +: KW] = exp_act[t][r];
    return f;
  endfunction

  task automatic model_default();
    for (int t = 0; t < NT; t++)
      for (int r = 0; r < HA; r++)
        exp_act[t][r] = hash_matrix_pkg::DEFAULT_Q_MATRIX[t][r];
  endtask

  // Table-major, row-minor: stream beat i lands in table i/HA, row i%HA.
  task automatic model_commit();
    for (int i = 0; i < NB; i++) exp_act[i / HA][i % HA] = rows[i];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_load();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Drives beats until n have been accepted (valid while ready); random gaps and stray start pulses optional.
  task automatic drive_beats(input int first, input int n, input int gap_pct, input bit noisy, output bit tmo);
    int  idx;
    int  cyc;
    bit  v;
    bit  acc;
    idx = first;
    cyc = 0;
    while (idx < n && cyc < 400) begin
      v = (gap_pct == 0) ? 1'b1 : ($urandom_range(99) >= gap_pct);
      row_valid_i = v;
      row_data_i  = rows[idx];
      start_i     = noisy ? 1'($urandom_range(1)) : 1'b0;
      acc = v && row_ready_o;
      tick();
      if (acc) idx++;
      cyc++;
    end
    row_valid_i = 1'b0;
    start_i     = 1'b0;
    tmo = (idx < n);
  endtask

  task automatic fill_rows(input bit seq);
    for (int i = 0; i < NB; i++) rows[i] = seq ? KW'(i + 1) : KW'($urandom);
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    model_default();
    for (int c = 0; c < 6; c++) begin
      checks++;
      if ({busy_o, freeze_o, row_ready_o, swap_done_o} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_ctrl cyc %0d got %b want 0000", c, {busy_o, freeze_o, row_ready_o, swap_done_o});
      end
      checks++;
      if (matrixes_o !== flat_exp()) begin
        errors++;
        $display("FAIL reset_matrix cyc %0d got %h want %h", c, matrixes_o, flat_exp());
      end
      tick();
    end
  endtask

  // Full load then commit after `hold` cycles of tables busy; ends in the first IDLE cycle.
  task automatic test_full_load(input string name, input bit seq, input int gap_pct, input bit noisy, input int hold);
    bit tmo;
    fill_rows(seq);
    tables_idle_i = (hold == 0);
    begin_load();
    checks++;
    if ({busy_o, freeze_o, row_ready_o, swap_done_o} !== 4'b1010) begin
      errors++;
      $display("FAIL %s_start got %b want 1010", name, {busy_o, freeze_o, row_ready_o, swap_done_o});
    end
    drive_beats(0, NB, gap_pct, noisy, tmo);
    checks++;
    if (tmo) begin
      errors++;
      $display("FAIL %s_beats timeout got 1 want 0", name);
    end
    for (int i = 0; i < hold; i++) begin
      checks++;
      if ({busy_o, freeze_o, row_ready_o, swap_done_o} !== 4'b1100 || matrixes_o !== flat_exp()) begin
        errors++;
        $display("FAIL %s_wait cyc %0d ctrl got %b want 1100, matrix got %h want %h",
                 name, i, {busy_o, freeze_o, row_ready_o, swap_done_o}, matrixes_o, flat_exp());
      end
      tick();
    end
    tables_idle_i = 1'b1;
    checks++;
    if ({busy_o, freeze_o, row_ready_o, swap_done_o} !== 4'b1100 || matrixes_o !== flat_exp()) begin
      errors++;
      $display("FAIL %s_last_wait ctrl got %b want 1100, matrix got %h want %h",
               name, {busy_o, freeze_o, row_ready_o, swap_done_o}, matrixes_o, flat_exp());
    end
    tick();
    model_commit();
    checks++;
    if ({busy_o, freeze_o, row_ready_o, swap_done_o} !== 4'b1101) begin
      errors++;
      $display("FAIL %s_commit_ctrl got %b want 1101", name, {busy_o, freeze_o, row_ready_o, swap_done_o});
    end
    checks++;
    if (matrixes_o !== flat_exp()) begin
      errors++;
      $display("FAIL %s_commit_matrix got %h want %h", name, matrixes_o, flat_exp());
    end
    tick();
    checks++;
    if ({busy_o, freeze_o, row_ready_o, swap_done_o} !== 4'b0000 || matrixes_o !== flat_exp()) begin
      errors++;
      $display("FAIL %s_idle ctrl got %b want 0000, matrix got %h want %h",
               name, {busy_o, freeze_o, row_ready_o, swap_done_o}, matrixes_o, flat_exp());
    end
  endtask

  task automatic test_seq_load();
    logic [KW-1:0] slice;
    test_full_load("seq", 1'b1, 0, 1'b0, 0);
    slice = matrixes_o[(2 * HA + 3) * KW +: KW];
    checks++;
    if (slice !== 16'h000E) begin
      errors++;
      $display("FAIL seq_t2r3 got %h want 000e", slice);
    end
  endtask

  task automatic test_wait_idle();
    test_full_load("hold", 1'b0, 0, 1'b0, 10);
  endtask

  task automatic test_random_gaps();
    test_full_load("gaps", 1'b0, 50, 1'b1, 0);
  endtask

  task automatic test_back_to_back();
    test_full_load("b2b_a", 1'b0, 0, 1'b0, 0);
    test_full_load("b2b_b", 1'b0, 20, 1'b0, 2);
  endtask

  task automatic test_abort_load();
    bit tmo;
    fill_rows(1'b0);
    tables_idle_i = 1'b1;
    begin_load();
    drive_beats(0, 7, 0, 1'b0, tmo);
    abort_i     = 1'b1;
    row_valid_i = 1'b1;
    row_data_i  = rows[7];
    tick();
    abort_i     = 1'b0;
    row_valid_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({busy_o, freeze_o, row_ready_o, swap_done_o} !== 4'b0000 || matrixes_o !== flat_exp()) begin
        errors++;
        $display("FAIL abort_load cyc %0d ctrl got %b want 0000, matrix got %h want %h",
                 c, {busy_o, freeze_o, row_ready_o, swap_done_o}, matrixes_o, flat_exp());
      end
      tick();
    end
    test_full_load("after_abort_load", 1'b0, 0, 1'b0, 0);
  endtask

  task automatic test_abort_wait();
    bit tmo;
    fill_rows(1'b0);
    tables_idle_i = 1'b0;
    begin_load();
    drive_beats(0, NB, 0, 1'b0, tmo);
    tick();
    tick();
    // Abort coincides with tables going idle; abort must win.
    abort_i       = 1'b1;
    tables_idle_i = 1'b1;
    tick();
    abort_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({busy_o, freeze_o, row_ready_o, swap_done_o} !== 4'b0000 || matrixes_o !== flat_exp()) begin
        errors++;
        $display("FAIL abort_wait cyc %0d ctrl got %b want 0000, matrix got %h want %h",
                 c, {busy_o, freeze_o, row_ready_o, swap_done_o}, matrixes_o, flat_exp());
      end
      tick();
    end
    test_full_load("after_abort_wait", 1'b0, 0, 1'b0, 0);
  endtask

  task automatic test_reset_mid();
    bit tmo;
    fill_rows(1'b0);
    tables_idle_i = 1'b1;
    begin_load();
    drive_beats(0, 12, 0, 1'b0, tmo);
    reset_i     = 1'b1;
    row_valid_i = 1'b1;
    row_data_i  = rows[12];
    tick();
    reset_i     = 1'b0;
    row_valid_i = 1'b0;
    model_default();
    checks++;
    if ({busy_o, freeze_o, row_ready_o, swap_done_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_ctrl got %b want 0000", {busy_o, freeze_o, row_ready_o, swap_done_o});
    end
    checks++;
    if (matrixes_o !== flat_exp()) begin
      errors++;
      $display("FAIL reset_mid_matrix got %h want %h", matrixes_o, flat_exp());
    end
    test_full_load("after_reset", 1'b0, 0, 1'b0, 0);
  endtask

  initial begin
    reset_i       = 1'b1;
    start_i       = 1'b0;
    abort_i       = 1'b0;
    row_valid_i   = 1'b0;
    row_data_i    = '0;
    tables_idle_i = 1'b0;
    model_default();
    test_reset();
    test_seq_load();
    test_wait_idle();
    test_random_gaps();
    test_back_to_back();
    test_abort_load();
    test_abort_wait();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
